// File: rtl/npu_pkg.sv
// npu_pkg: shared region/op codes, default layer sizes and loader states
package npu_pkg;
  localparam logic [2:0] REG_IMG = 3'b000;
  localparam logic [2:0] REG_W1 = 3'b001;
  localparam logic [2:0] REG_W2 = 3'b010;
  localparam logic [2:0] REG_FC1 = 3'b011;
  localparam logic [2:0] REG_FC2 = 3'b100;
  localparam logic [2:0] REG_OP = 3'b101;
  localparam logic [11:0] OP_RST = 12'd0;
  localparam logic [11:0] OP_TRIG = 12'd1;
  localparam logic [11:0] OP_REQ = 12'd2;
  localparam int N_IMG_DEF = 240;
  localparam int N_W1_DEF = 90;
  localparam int N_W2_DEF = 90;
  localparam int N_FC1_DEF = 1320;
  localparam int N_FC2_DEF = 10;
  typedef enum logic [2:0] {
    S_IDLE, S_NPU_RST, S_LOAD, S_TRIG, S_GAP, S_POLL, S_PWAIT
  } state_t;
endpackage

// File: rtl/npu_region_counter.sv
// npu_region_counter: walks {region, offset} through the layer regions in load order
module npu_region_counter
  import npu_pkg::*;
#(
  parameter int N_IMG = N_IMG_DEF,
  parameter int N_W1 = N_W1_DEF,
  parameter int N_W2 = N_W2_DEF,
  parameter int N_FC1 = N_FC1_DEF,
  parameter int N_FC2 = N_FC2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_adv,
  output logic [2:0]  o_region,
  output logic [11:0] o_offset,
  output logic        o_last
);
  logic [2:0]  r_region;
  logic [11:0] r_offset;
  logic [11:0] w_lim;
  logic        w_wrap;
  // last offset of the region currently being filled
  always_comb
    w_lim = r_region == REG_IMG ? 12'(N_IMG - 1) :
            r_region == REG_W1  ? 12'(N_W1 - 1)  :
            r_region == REG_W2  ? 12'(N_W2 - 1)  :
            r_region == REG_FC1 ? 12'(N_FC1 - 1) : 12'(N_FC2 - 1);
  assign w_wrap = r_offset == w_lim;
  assign o_last = r_region == REG_FC2 && r_offset == 12'(N_FC2 - 1);
  assign o_region = r_region;
  assign o_offset = r_offset;
  // advance one beat, rolling into the next region at the end of each one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_region <= '0;
      r_offset <= '0;
    end else if (i_clr) begin
      r_region <= '0;
      r_offset <= '0;
    end else if (i_adv) begin
      r_offset <= w_wrap ? '0 : r_offset + 12'd1;
      r_region <= w_wrap ? r_region + 3'd1 : r_region;
    end
endmodule

// File: rtl/npu_host_loader.sv
// npu_host_loader: streams image/weights into the NPU, triggers it and polls for the result
module npu_host_loader
  import npu_pkg::*;
#(
  parameter int N_IMG = N_IMG_DEF,
  parameter int N_W1 = N_W1_DEF,
  parameter int N_W2 = N_W2_DEF,
  parameter int N_FC1 = N_FC1_DEF,
  parameter int N_FC2 = N_FC2_DEF,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        npu_en,
  output logic [14:0] npu_addr,
  output logic [31:0] npu_wdata,
  input  logic [31:0] npu_rdata,
  output logic        busy,
  output logic        done,
  output logic [23:0] result,
  output logic        timeout
);
  state_t      r_state, w_next;
  logic        r_en, r_done, r_timeout;
  logic [14:0] r_addr;
  logic [31:0] r_wdata;
  logic [23:0] r_result;
  logic [15:0] r_gap, r_polls;
  logic        w_en, w_clr, w_adv, w_last, w_gap_end, w_poll_lim, w_npu_done;
  logic [14:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_region;
  logic [11:0] w_offset;
  logic        w_unused;
  assign w_unused = &{1'b0, npu_rdata[30:24]};
  assign w_npu_done = npu_rdata[31];
  assign w_gap_end = r_gap == 16'(POLL_GAP - 1);
  assign w_poll_lim = r_polls == 16'(POLL_MAX);
  npu_region_counter #(
    .N_IMG(N_IMG), .N_W1(N_W1), .N_W2(N_W2), .N_FC1(N_FC1), .N_FC2(N_FC2)
  ) u_cnt (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_adv(w_adv),
    .o_region(w_region), .o_offset(w_offset), .o_last(w_last)
  );
  // next state plus the NPU access to register for the following cycle
  always_comb begin
    w_next = r_state;
    w_en = 1'b0;
    w_addr = r_addr;
    w_wdata = r_wdata;
    w_clr = 1'b0;
    w_adv = 1'b0;
    case (r_state)
      S_IDLE: w_next = start ? S_NPU_RST : S_IDLE;
      S_NPU_RST: begin
        w_en = 1'b1;
        w_addr = {REG_OP, OP_RST};
        w_wdata = '0;
        w_clr = 1'b1;
        w_next = S_LOAD;
      end
      S_LOAD: begin
        w_adv = src_valid;
        w_en = src_valid;
        w_addr = src_valid ? {w_region, w_offset} : r_addr;
        w_wdata = src_valid ? {{24{src_data[7]}}, src_data} : r_wdata;
        w_next = src_valid && w_last ? S_TRIG : S_LOAD;
      end
      S_TRIG: begin
        w_en = 1'b1;
        w_addr = {REG_OP, OP_TRIG};
        w_wdata = '0;
        w_next = S_GAP;
      end
      S_GAP: w_next = w_gap_end ? S_POLL : S_GAP;
      S_POLL: begin
        w_en = 1'b1;
        w_addr = {REG_OP, OP_REQ};
        w_wdata = '0;
        w_next = S_PWAIT;
      end
      S_PWAIT: w_next = w_npu_done || w_poll_lim ? S_IDLE : S_GAP;
      default: w_next = S_IDLE;
    endcase
  end
  // state and registered NPU port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_en <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_en <= w_en;
      r_addr <= w_addr;
      r_wdata <= w_wdata;
    end
  // poll spacing, poll count and the completion/timeout status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_gap <= '0;
      r_polls <= '0;
      r_done <= 1'b0;
      r_result <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_gap <= r_state == S_GAP ? r_gap + 16'd1 : '0;
      r_polls <= r_state == S_NPU_RST ? '0 : r_state == S_POLL ? r_polls + 16'd1 : r_polls;
      r_done <= r_state == S_PWAIT && w_npu_done;
      r_result <= r_state == S_PWAIT && w_npu_done ? npu_rdata[23:0] : r_result;
      r_timeout <= r_state == S_IDLE && start ? 1'b0 :
                   r_state == S_PWAIT && !w_npu_done && w_poll_lim ? 1'b1 : r_timeout;
    end
  assign src_ready = r_state == S_LOAD;
  assign busy = r_state != S_IDLE;
  assign npu_en = r_en;
  assign npu_addr = r_addr;
  assign npu_wdata = r_wdata;
  assign done = r_done;
  assign result = r_result;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_npu_host_loader.sv
// tb_npu_host_loader: access-order model plus directed load/stall/poll/timeout/reset scenarios
module tb_npu_host_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic        npu_en;
  logic [14:0] npu_addr;
  logic [31:0] npu_wdata;
  logic [31:0] npu_rdata;
  logic        busy, done, timeout;
  logic [23:0] result;

  int vecs = 0;
  int errs = 0;
  int idx = 0;
  bit hs = 0;
  bit src_on = 0;
  bit stall_armed = 0;
  int stall_left = 0;
  int cyc = 0;
  bit active = 0;
  int polls_seen = 0;
  int done_on = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  bit in_load = 0;
  bit resume_pending = 0;
  logic [14:0] resume_addr = '0;
  int last_poll = -1;
  logic [46:0] q[$];
  int sz[5] = '{240, 90, 90, 1320, 10};

  npu_host_loader #(.POLL_MAX(3)) dut (
    .clk(clk), .rst(rst), .start(start), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .npu_en(npu_en), .npu_addr(npu_addr), .npu_wdata(npu_wdata),
    .npu_rdata(npu_rdata), .busy(busy), .done(done), .result(result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // NPU side: reports done with result -10 on the configured require number
  assign npu_rdata = (done_on != 0 && npu_en && npu_addr == 15'h5002 && polls_seen == done_on)
                     ? 32'h80FFFFF6 : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) hs <= src_valid && src_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected NPU access sequence: reset op, all regions in order, trigger, then the polls
  task automatic build(input int n_polls);
    int g;
    int v;
    q.delete();
    q.push_back({15'h5000, 32'h0});
    g = 0;
    for (int r = 0; r < 5; r++)
      for (int o = 0; o < sz[r]; o++) begin
        v = g % 256;
        v = v >= 128 ? v - 256 : v;
        q.push_back({15'(r * 4096 + o), 32'(v)});
        g++;
      end
    q.push_back({15'h5001, 32'h0});
    for (int p = 0; p < n_polls; p++) q.push_back({15'h5002, 32'h0});
  endtask

  // byte source: bytes are index mod 256, with an optional 7-cycle stall at image offset 100
  initial begin
    src_valid = 1'b0;
    src_data = 8'h0;
    forever begin
      @(negedge clk);
      if (hs) idx++;
      if (stall_armed && idx == 100) begin
        stall_armed = 0;
        stall_left = 7;
      end
      src_valid = src_on && stall_left == 0;
      if (stall_left > 0) stall_left--;
      src_data = 8'(idx);
    end
  end

  // compare every NPU access against the model and gather per-run observations
  always @(negedge clk) begin
    logic [46:0] e;
    if (active && !rst) begin
      if (done) done_cnt++;
      if (in_load && !npu_en) begin
        gap_cnt++;
        resume_pending = 1;
      end
      if (npu_en) begin
        vecs++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL access: got %h/%h expected none", npu_addr, npu_wdata);
        end else begin
          e = q.pop_front();
          if ({npu_addr, npu_wdata} !== e) begin
            errs++;
            $display("FAIL access: got %h/%h expected %h/%h", npu_addr, npu_wdata, e[46:32], e[31:0]);
          end
        end
        if (resume_pending && in_load) begin
          resume_addr = npu_addr;
          resume_pending = 0;
        end
        if (npu_addr == 15'h0000) in_load = 1;
        if (npu_addr == 15'h5001) in_load = 0;
        if (npu_addr == 15'h100F) chk("byte_ff_sext", npu_wdata, 32'hFFFFFFFF);
        if (npu_addr == 15'h5002) begin
          polls_seen++;
          if (last_poll >= 0) chk("poll_spacing", 32'(cyc - last_poll), 32'd6);
          last_poll = cyc;
        end
      end
    end
  end

  task automatic run(input bit stall, input int d_on, input int n_polls, input bit exp_to, input string tag);
    int t;
    build(n_polls);
    idx = 0;
    polls_seen = 0;
    done_on = d_on;
    done_cnt = 0;
    gap_cnt = 0;
    in_load = 0;
    resume_pending = 0;
    resume_addr = '0;
    last_poll = -1;
    stall_armed = stall;
    src_on = 1;
    active = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "_timeout_cleared"}, 32'(timeout), 32'd0);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_queue_left"}, 32'(q.size()), 32'd0);
    chk({tag, "_polls"}, 32'(polls_seen), 32'(n_polls));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(d_on != 0));
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    if (d_on != 0) chk({tag, "_result"}, 32'(result), 32'h00FFFFF6);
    chk({tag, "_load_gaps"}, 32'(gap_cnt), stall ? 32'd7 : 32'd0);
    if (stall) chk({tag, "_resume_addr"}, 32'(resume_addr), 32'h0064);
    src_on = 0;
    active = 0;
  endtask

  initial begin
    int n;
    int t;
    rst = 1'b1;
    #1;
    chk("rst_npu_en", 32'(npu_en), 32'd0);
    chk("rst_npu_addr", 32'(npu_addr), 32'd0);
    chk("rst_npu_wdata", npu_wdata, 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (npu_en) n++;
    end
    chk("idle_no_access", 32'(n), 32'd0);

    run(0, 3, 3, 0, "full");
    run(1, 1, 1, 0, "stall");
    run(0, 0, 3, 1, "tmo");

    build(1);
    idx = 0;
    polls_seen = 0;
    done_on = 0;
    src_on = 1;
    active = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (idx < 920 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_fc1", 32'(idx >= 920), 32'd1);
    active = 0;
    rst = 1'b1;
    #1;
    chk("midrst_npu_en", 32'(npu_en), 32'd0);
    chk("midrst_npu_addr", 32'(npu_addr), 32'd0);
    chk("midrst_npu_wdata", npu_wdata, 32'd0);
    chk("midrst_src_ready", 32'(src_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    src_on = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 1, 1, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/npu_host_loader.md
Name: npu_host_loader

Overview:
Host-side initiator for the NPU address-mapped port. It streams the input image and all layer weights from a byte source into the NPU address space, then issues the rst, trigger and require operations, and polls until the NPU reports done. It sits between the SoC DMA/byte stream and the NPU's en/addr/w_data/r_data port. It is the master end of the protocol the NPU top decodes.

Parameters:
N_IMG, 240, image pixels (16x15), region 3'b000
N_W1, 90, conv1 weights (3*3*10), region 3'b001
N_W2, 90, conv2 weights (3*3*10), region 3'b010
N_FC1, 1320, fc1 weights (132*10), region 3'b011
N_FC2, 10, fc2 weights, region 3'b100
POLL_GAP, 4, idle cycles between require polls
POLL_MAX, 65535, max polls before timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins one full inference sequence
src_data  in  8  signed byte (pixel/weight) in the fixed region order
src_valid  in  1  src_data valid
src_ready  out  1  loader accepts src_data this cycle
npu_en  out  1  NPU access strobe
npu_addr  out  15  {region[2:0], offset[11:0]}
npu_wdata  out  32  write data
npu_rdata  in  32  require response: bit31 = done, bits[23:0] = signed result
busy  out  1  sequence in progress
done  out  1  one-cycle pulse; result valid
result  out  24  signed fc2 result, held until next start
timeout  out  1  sticky; set when the poll limit is hit, cleared by start

Behaviour:
- Reset (async): state IDLE; npu_en=0, npu_addr=0, npu_wdata=0, src_ready=0, busy=0, done=0, result=0, timeout=0. All counters are 0.
- Outputs npu_en, npu_addr and npu_wdata are registered.
- IDLE: start -> NPU_RST. start is ignored while busy.
- NPU_RST: one cycle with npu_en=1, addr=15'h5000 (region 101, op 0), wdata=0 -> LOAD, region=0, offset=0.
- LOAD: src_ready=1 combinationally in this state.
  - Each src_valid&&src_ready handshake produces, next cycle, npu_en=1, addr={region,offset}, wdata = src_data sign-extended to 32 bits.
  - No handshake -> npu_en=0.
  - offset increments per beat. At offset==N_region-1 the offset wraps to 0 and region increments.
  - After the last fc2 beat (region 4, offset N_FC2-1) -> TRIG. src_ready drops the same cycle.
- TRIG: one cycle, npu_en=1, addr=15'h5001 -> GAP.
- GAP: counts POLL_GAP cycles with npu_en=0 -> POLL.
- POLL: one cycle, npu_en=1, addr=15'h5002 -> PWAIT. The poll counter increments.
- PWAIT: samples npu_rdata exactly 1 cycle after the POLL strobe.
  - bit31=1: result<=rdata[23:0], done pulse 1 cycle, -> IDLE.
  - bit31=0 and polls<POLL_MAX: -> GAP.
  - bit31=0 and polls==POLL_MAX: timeout<=1, -> IDLE (no done).
- busy=1 in every state except IDLE.
- Minimum load length is 1750 NPU writes. The minimum for start to done is 1750 + 1 + 1 + POLL_GAP + 2 cycles, with continuous src_valid and done on the first poll.
- src_valid low mid-region: the loader stalls and the offset holds. There is no timeout on the source.
- start asserted during busy: ignored. It does not restart the sequence or clear timeout.
- Async rst mid-sequence: immediate return to the reset values. A partially loaded NPU is reinitialised by the next start via NPU_RST.
- Offsets never exceed 12 bits: N_FC1-1 = 1319 < 4096.

Decomposition:
- Shared package npu_pkg holds:
  - region codes (REG_IMG=3'b000 .. REG_FC2=3'b100, REG_OP=3'b101);
  - op codes (OP_RST=12'd0, OP_TRIG=12'd1, OP_REQ=12'd2);
  - the default layer sizes;
  - the state enum.
- One natural sub-module, npu_region_counter: region/offset counter with per-region limit lookup and a last-beat flag.

Test Plan:
- Reset defaults: assert rst with no clock edge -> all outputs 0 immediately. Release rst, no start -> npu_en stays 0 for 100 cycles.
- Full load order: start, src_valid held high, bytes = index mod 256 -> first access 15'h5000. Next, 240 writes to 15'h0000..15'h00EF; byte 0xFF appears as wdata 32'hFFFFFFFF. Next, 90 writes to 15'h1000..15'h1059, 90 to 15'h2000..15'h2059, 1320 to 15'h3000..15'h3527, 10 to 15'h4000..15'h4009, then 15'h5001.
- Source stall: drop src_valid for 7 cycles at image offset 100 -> npu_en=0 during the stall, resumes at 15'h0064. No address is skipped or duplicated.
- Polling: the NPU model returns done on the 3rd require with rdata=32'h80FFFFF6 -> polls spaced POLL_GAP+2 cycles apart. done pulses once, result=24'hFFFFF6 (-10), busy falls.
- Timeout: with POLL_MAX=3 and done never set -> exactly 3 polls, timeout=1, no done pulse. A new start clears timeout.
- Reset mid-load at fc1 offset 500 -> outputs cleared asynchronously. A new start begins again with 15'h5000.
